// File: rtl/psum_requantizer.sv
// Accumulates partial-sum vectors over num_tiles K-tiles, then rounds, shifts by S and saturates
// each lane to DATA_WIDTH. The result is offered to the activation stage on a valid/ready handshake.
module psum_requantizer #(
  parameter int DATA_WIDTH = 11,
  parameter int SA_LENGTH  = 256,
  parameter int PSUM_WIDTH = 27,
  parameter int ACC_WIDTH  = 32,
  parameter int S          = 7,
  parameter int TILE_W     = 8
) (
  input  logic                         clk,
  input  logic                         async_rst,
  input  logic                         sync_rst,
  input  logic                         start,
  input  logic [TILE_W-1:0]            num_tiles,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PSUM_WIDTH-1:0] psum_in [SA_LENGTH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out [SA_LENGTH],
  output logic                         sat_flag
);

  typedef enum logic [1:0] {IDLE, ACCUM, REQ, OUT} state_t;

  // All lane arithmetic runs one bit wider than the accumulator so sums and rounding cannot wrap.
  localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] RND     = {{(ACC_WIDTH+1-S){1'b0}}, 1'b1, {(S-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MAX = {{(ACC_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN = {{(ACC_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state;
  logic [TILE_W-1:0]            tile_cnt;
  logic [TILE_W-1:0]            tiles;
  logic signed [ACC_WIDTH-1:0]  acc      [SA_LENGTH];

  logic signed [ACC_WIDTH:0]    acc_ext  [SA_LENGTH];
  logic signed [ACC_WIDTH:0]    psum_ext [SA_LENGTH];
  logic signed [ACC_WIDTH:0]    sum      [SA_LENGTH];
  logic signed [ACC_WIDTH:0]    rnd      [SA_LENGTH];
  logic signed [ACC_WIDTH-1:0]  acc_next [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] out_next [SA_LENGTH];
  logic                         sat_any;

  assign busy     = (state != IDLE);
  assign in_ready = (state == ACCUM);

  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < SA_LENGTH; i++) begin
      acc_ext[i]  = {acc[i][ACC_WIDTH-1], acc[i]};
      psum_ext[i] = {{(ACC_WIDTH+1-PSUM_WIDTH){psum_in[i][PSUM_WIDTH-1]}}, psum_in[i]};
      sum[i]      = acc_ext[i] + psum_ext[i];
      if (sum[i] > ACC_MAX)
        acc_next[i] = ACC_MAX[ACC_WIDTH-1:0];
      else if (sum[i] < ACC_MIN)
        acc_next[i] = ACC_MIN[ACC_WIDTH-1:0];
      else
        acc_next[i] = sum[i][ACC_WIDTH-1:0];

      rnd[i] = (acc_ext[i] + RND) >>> S;
      if (rnd[i] > OUT_MAX) begin
        out_next[i] = OUT_MAX[DATA_WIDTH-1:0];
        sat_any     = 1'b1;
      end else if (rnd[i] < OUT_MIN) begin
        out_next[i] = OUT_MIN[DATA_WIDTH-1:0];
        sat_any     = 1'b1;
      end else begin
        out_next[i] = rnd[i][DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state     <= IDLE;
      tile_cnt  <= '0;
      tiles     <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < SA_LENGTH; i++) begin
        acc[i] <= '0;
        out[i] <= '0;
      end
    end else if (sync_rst) begin
      state     <= IDLE;
      tile_cnt  <= '0;
      tiles     <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < SA_LENGTH; i++) begin
        acc[i] <= '0;
        out[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            tile_cnt <= '0;
            tiles    <= (num_tiles == '0) ? TILE_W'(1) : num_tiles;
            for (int i = 0; i < SA_LENGTH; i++) acc[i] <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            tile_cnt <= tile_cnt + 1'b1;
            for (int i = 0; i < SA_LENGTH; i++) acc[i] <= acc_next[i];
            if (tile_cnt == tiles - 1'b1) state <= REQ;
          end
        end
        REQ: begin
          for (int i = 0; i < SA_LENGTH; i++) out[i] <= out_next[i];
          sat_flag  <= sat_any;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_requantizer.sv
// Directed-vector bench for psum_requantizer with a 4-lane array.
module tb_psum_requantizer;

  logic                clk = 1'b0;
  logic                async_rst;
  logic                sync_rst;
  logic                start;
  logic [7:0]          num_tiles;
  logic                busy;
  logic                in_valid;
  logic                in_ready;
  logic signed [26:0]  psum_in [4];
  logic                out_valid;
  logic                out_ready;
  logic signed [10:0]  out [4];
  logic                sat_flag;

  int checks   = 0;
  int failures = 0;

  psum_requantizer #(.SA_LENGTH(4)) dut (
    .clk(clk), .async_rst(async_rst), .sync_rst(sync_rst), .start(start),
    .num_tiles(num_tiles), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_psum(input int a, input int b, input int c, input int d);
    psum_in[0] = 27'(a);
    psum_in[1] = 27'(b);
    psum_in[2] = 27'(c);
    psum_in[3] = 27'(d);
  endtask

  task automatic start_job(input int n);
    start     = 1'b1;
    num_tiles = 8'(n);
    tick();
    start     = 1'b0;
  endtask

  task automatic beat(input int a, input int b, input int c, input int d);
    in_valid = 1'b1;
    set_psum(a, b, c, d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic signed [10:0] exp [4];
    async_rst = 1'b0; sync_rst = 1'b0; start = 1'b0; num_tiles = '0;
    in_valid = 1'b0; out_ready = 1'b0; set_psum(0, 0, 0, 0);
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
    checks++; if (out[0] !== 11'sd0) begin failures++; $display("FAIL reset_out0 got=%0d exp=0", out[0]); end
    tick(); tick();
    async_rst = 1'b1;
    tick();
    start_job(2);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL accum_in_ready got=%b exp=1", in_ready); end
    beat(1000, 1000, 1000, 1000);
    #2 async_rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_mid_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL async_mid_in_ready got=%b exp=0", in_ready); end
    tick();
    async_rst = 1'b1;
    tick();
    start_job(1);
    beat(128, 0, 0, 0);
    tick();
    exp = '{11'sd1, 11'sd0, 11'sd0, 11'sd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (out[i] !== exp[i]) begin failures++; $display("FAIL reset_fresh_acc[%0d] got=%0d exp=%0d", i, out[i], exp[i]); end
    end
    handshake();
  endtask

  task automatic test_accum_round();
    logic signed [10:0] exp [4];
    start_job(2);
    beat(384, -100, 64, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t2_mid_out_valid got=%b exp=0", out_valid); end
    beat(384, -100, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t2_req_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL t2_req_in_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t2_latency_out_valid got=%b exp=1", out_valid); end
    exp = '{11'sd6, -11'sd2, 11'sd1, 11'sd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (out[i] !== exp[i]) begin failures++; $display("FAIL t2_out[%0d] got=%0d exp=%0d", i, out[i], exp[i]); end
    end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL t2_sat_flag got=%b exp=0", sat_flag); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t2_post_hs_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_post_hs_busy got=%b exp=0", busy); end
    checks++; if (out[0] !== 11'sd6) begin failures++; $display("FAIL t2_out_kept got=%0d exp=6", out[0]); end
  endtask

  task automatic test_saturation();
    logic signed [10:0] exp [4];
    start_job(1);
    beat(200000, -200000, 130943, 130944);
    tick();
    exp = '{11'sd1023, -11'sd1024, 11'sd1023, 11'sd1023};
    for (int i = 0; i < 4; i++) begin
      checks++; if (out[i] !== exp[i]) begin failures++; $display("FAIL t3_out[%0d] got=%0d exp=%0d", i, out[i], exp[i]); end
    end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL t3_sat_flag got=%b exp=1", sat_flag); end
    handshake();
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL t3_sat_kept got=%b exp=1", sat_flag); end
  endtask

  // 40 full-scale beats overflow a 32-bit lane; saturation keeps the sign.
  task automatic test_acc_sat();
    logic signed [10:0] exp [4];
    start_job(40);
    for (int k = 0; k < 40; k++) beat(67108863, -67108864, 1, -1);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL accsat_out_valid got=%b exp=1", out_valid); end
    exp = '{11'sd1023, -11'sd1024, 11'sd0, 11'sd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (out[i] !== exp[i]) begin failures++; $display("FAIL accsat_out[%0d] got=%0d exp=%0d", i, out[i], exp[i]); end
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic signed [10:0] exp [4];
    start_job(3);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      if (in_valid) set_psum(128, 256, -128, 64);
      else          set_psum(10000, 10000, 10000, 10000);
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t4_early_out_valid k=%0d got=%b exp=0", k, out_valid); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t4_busy k=%0d got=%b exp=1", k, busy); end
    end
    in_valid = 1'b0;
    tick();
    exp = '{11'sd3, 11'sd6, -11'sd3, 11'sd2};
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      set_psum(50000, 50000, 50000, 50000);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t4_hold_out_valid k=%0d got=%b exp=1", k, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL t4_hold_in_ready k=%0d got=%b exp=0", k, in_ready); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (out[i] !== exp[i]) begin failures++; $display("FAIL t4_out[%0d] k=%0d got=%0d exp=%0d", i, k, out[i], exp[i]); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t4_busy_before_hs got=%b exp=1", busy); end
    handshake();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_busy_after_hs got=%b exp=0", busy); end
  endtask

  task automatic test_zero_tiles_busy_start();
    logic signed [10:0] exp [4];
    in_valid = 1'b1;
    set_psum(12800, 12800, 12800, 12800);
    start_job(0);
    in_valid  = 1'b0;
    start     = 1'b1;
    num_tiles = 8'd5;
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL t5_still_accum got=%b exp=1", in_ready); end
    beat(256, -256, 0, 0);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t5_out_valid got=%b exp=1", out_valid); end
    exp = '{11'sd2, -11'sd2, 11'sd0, 11'sd0};
    for (int i = 0; i < 4; i++) begin
      checks++; if (out[i] !== exp[i]) begin failures++; $display("FAIL t5_out[%0d] got=%0d exp=%0d", i, out[i], exp[i]); end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t5_start_in_out got=%b exp=1", out_valid); end
    handshake();
  endtask

  task automatic test_sync_rst();
    start_job(1);
    beat(200000, 200000, 200000, 200000);
    tick();
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL t6_pre_sat got=%b exp=1", sat_flag); end
    sync_rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL t6_sync_not_async got=%b exp=1", out_valid); end
    tick();
    sync_rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t6_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_busy got=%b exp=0", busy); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL t6_sat_flag got=%b exp=0", sat_flag); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out[i] !== 11'sd0) begin failures++; $display("FAIL t6_out[%0d] got=%0d exp=0", i, out[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_accum_round();
    test_saturation();
    test_acc_sat();
    test_backpressure();
    test_zero_tiles_busy_start();
    test_sync_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
